// File: rtl/snn_param_memory.sv
// rtl/snn_param_memory.sv - double-banked SNN weight/delay store with random and streamed shadow loads
// Shadow bank is loaded by the host; commit copies it atomically into the active bank on all_data_out.
module snn_param_memory #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 320,
  parameter int ADDR_W      = 9,
  parameter int AUTO_COMMIT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    write_enable,
  input  logic                    load_start,
  input  logic                    stream_valid,
  input  logic                    commit,
  output logic [DATA_W-1:0]       data_out,
  output logic [DEPTH*DATA_W-1:0] all_data_out,
  output logic                    load_done,
  output logic                    overflow,
  output logic                    committed
);

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0]       shadow_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] active_q;
  logic [DATA_W-1:0]       data_out_q;
  logic [ADDR_W:0]         ptr_q;
  logic                    load_done_q;
  logic                    overflow_q;
  logic                    committed_q;
  logic                    auto_req_q;

  logic addr_ok;
  logic stream_acc;
  logic stream_last;
  logic do_commit;

  assign addr_ok     = ({1'b0, addr} < DEPTH_P);
  assign stream_acc  = stream_valid && !load_start && (ptr_q < DEPTH_P);
  assign stream_last = ((ptr_q + 1'b1) == DEPTH_P);
  assign do_commit   = commit || auto_req_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
      active_q    <= '0;
      data_out_q  <= '0;
      ptr_q       <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      committed_q <= 1'b0;
      auto_req_q  <= 1'b0;
    end else begin
      // Stream path wins over a same-cycle random write since both share data_in.
      if (stream_acc)
        shadow_q[ptr_q[ADDR_W-1:0]] <= data_in;
      else if (write_enable && addr_ok)
        shadow_q[addr] <= data_in;

      data_out_q <= addr_ok ? shadow_q[addr] : '0;

      if (load_start) begin
        ptr_q       <= '0;
        load_done_q <= 1'b0;
        overflow_q  <= 1'b0;
      end else if (stream_valid) begin
        if (ptr_q < DEPTH_P) begin
          ptr_q <= ptr_q + 1'b1;
          if (stream_last) load_done_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      auto_req_q  <= (AUTO_COMMIT != 0) && stream_acc && stream_last;
      committed_q <= do_commit;

      // Non-blocking copy samples the shadow as it was before this edge.
      if (do_commit)
        for (int i = 0; i < DEPTH; i++) active_q[i*DATA_W +: DATA_W] <= shadow_q[i];
    end
  end

  assign data_out     = data_out_q;
  assign all_data_out = active_q;
  assign load_done    = load_done_q;
  assign overflow     = overflow_q;
  assign committed    = committed_q;

endmodule

// File: doc/snn_param_memory.md
# snn_param_memory

Parametrised configuration store for the SNN datapath, holding per-synapse weight/delay bytes. The host loads a shadow bank either by random-access writes or by an auto-incrementing stream. A commit then copies the whole shadow bank into an active bank that drives the flat parallel bus into the network core. Reloading while the network runs therefore never exposes a half-written configuration.

## Interface
Parameters:
- `DATA_W`, 8: bits per entry.
- `DEPTH`, 320: number of entries.
- `ADDR_W`, 9: address width; must satisfy 2^ADDR_W >= DEPTH.
- `AUTO_COMMIT`, 0: if 1, a commit is generated internally when a stream load completes.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high; sampled on the `clk` rising edge.
- `data_in`  in  DATA_W  — write data, shared by the random and stream paths.
- `addr`  in  ADDR_W  — random-access write/read address into the shadow bank.
- `write_enable`  in  1  — random write of `data_in` to `shadow[addr]`.
- `load_start`  in  1  — clears the stream pointer, `load_done` and `overflow`.
- `stream_valid`  in  1  — stream write of `data_in` to `shadow[ptr]`, then `ptr++`.
- `commit`  in  1  — copy the shadow bank to the active bank.
- `data_out`  out  DATA_W  — registered read of `shadow[addr]`.
- `all_data_out`  out  DEPTH*DATA_W  — active bank, flat; entry i is at `[i*DATA_W +: DATA_W]`.
- `load_done`  out  1  — level; stream pointer has reached DEPTH.
- `overflow`  out  1  — sticky; a stream write was attempted while `ptr == DEPTH`.
- `committed`  out  1  — one-cycle pulse, high in the cycle the new `all_data_out` first appears.

## Operation
- Storage: `shadow[0:DEPTH-1]`, the active bank (the `all_data_out` register), and a stream pointer `ptr` of ADDR_W+1 bits, range 0..DEPTH.
- Reset, highest priority:
  - All shadow entries, `all_data_out` and `data_out` go to 0.
  - `ptr` goes to 0.
  - `load_done`, `overflow`, `committed` and the auto-commit request go to 0.
  - Reset asserted mid-load or mid-commit aborts the operation; no partial commit is performed.
- `load_start`: `ptr` goes to 0 and `load_done`/`overflow` clear.
  - `stream_valid` in the same cycle is ignored.
  - Shadow contents are unchanged.
- Stream write, when `stream_valid` is high and `load_start` is low:
  - If `ptr < DEPTH`: `shadow[ptr] <= data_in` and `ptr <= ptr+1`. If `ptr+1 == DEPTH`, `load_done` goes to 1 at this edge.
  - If `ptr == DEPTH`: the write is dropped and `overflow` goes to 1. `ptr` holds.
- Random write: `write_enable` high and `addr < DEPTH` writes `shadow[addr] <= data_in`.
  - `addr >= DEPTH`: the write is silently dropped.
  - If a stream write is accepted in the same cycle, the stream wins and the random write is dropped, even if the addresses differ. The shared `data_in` makes the two unambiguous only this way.
- Read: `data_out <= (addr < DEPTH) ? shadow[addr] : 0` every non-reset cycle.
  - Read-before-write: a same-cycle write to `addr` returns the old value.
- Commit: on an edge where `commit` is high or the auto-commit request is set:
  - `all_data_out` takes the shadow contents as they were before that edge; writes in the same cycle are not included.
  - `committed` goes to 1 for exactly one cycle.
  - Commit during an unfinished load is legal and copies the partial shadow bank.
- AUTO_COMMIT=1: the edge that sets `load_done` also sets the auto-commit request.
  - At the next edge the commit executes and the request clears. That commit includes the last stream byte.
  - An external `commit` coinciding with the request produces a single commit.
- AUTO_COMMIT=0: the request is never set.

## Timing
- `data_out`: 1-cycle latency from `addr`.
- `all_data_out` and `committed`: valid in the cycle after the commit edge samples `commit` high. This is 1 cycle of latency; `all_data_out` then holds until the next commit or reset.
- Auto-commit: `all_data_out` reflects the full stream 2 edges after the final `stream_valid` edge.
- `load_done` rises in the cycle after the DEPTH-th accepted stream write.
- Back-to-back: `stream_valid` may stay high every cycle; one entry is written per cycle with no stall.
- No combinational path from any input to any output.

## Test plan
- Reset: write 0xAA to addr 5, commit, then pulse `reset` for 1 cycle -> next cycle `all_data_out == 0`, `data_out == 0`, `load_done == 0`, `overflow == 0`, `committed == 0`.
- Stream load with DEPTH=320, AUTO_COMMIT=0:
  - `load_start`, then 320 consecutive `stream_valid` with data = i[7:0] -> `load_done` rises 1 cycle after the last write and `all_data_out` is still 0.
  - Pulse `commit` -> next cycle entry i == i[7:0] and `committed` pulses once.
- Overflow and collision:
  - A 321st `stream_valid` -> `overflow` goes 1 and stays 1; shadow is unchanged.
  - `write_enable` (addr 3, 0x55) together with `stream_valid` at `ptr == 0` (data 0x55) -> only entry 0 is written; entry 3 keeps its old value.
- Read and range:
  - Write 0x3C to addr 7, then read addr 7 -> `data_out == 0x3C` one cycle later.
  - Same-cycle write 0x11 and read at addr 7 -> `data_out == 0x3C`.
  - `addr == 400` write -> dropped; read returns 0.
- AUTO_COMMIT=1:
  - Full 320-byte stream -> `committed` pulses 2 cycles after the last write, with entry 319 correct.
  - External `commit` asserted that same cycle -> a single `committed` pulse.
- Mid-operation:
  - `commit` after 100 stream bytes -> entries 0..99 new, 100..319 old.
  - `reset` asserted on the commit edge -> `all_data_out == 0` and no `committed` pulse.
